// File: rtl/jt49_bus_arb_if.sv
// jt49_bus_arb_if: requester handshakes and the jt49 register bus, bundled for jt49_bus_arb.
// Latency: none, wires only.
// Backpressure: requesters hold valid and payload until the arbiter pulses their ack.
//
// Modports:
//   slave  - arbiter view: takes both requests in, drives acks and the PSG bus.
//   master - requester/PSG view: drives requests and psg_dout, observes everything else.
// With JT49_ARB_RD_EN defined the read signals (reqN_rd, psg_dout, rd_data, rd_valid) exist.
interface jt49_bus_arb_if;
    logic       req0_valid;
    logic [3:0] req0_addr;
    logic [7:0] req0_din;
    logic       req0_ack;
    logic       req1_valid;
    logic [3:0] req1_addr;
    logic [7:0] req1_din;
    logic       req1_ack;
    logic [3:0] psg_addr;
    logic [7:0] psg_din;
    logic       psg_cs_n;
    logic       psg_wr_n;
    logic       grant_id;
    logic       busy;
`ifdef JT49_ARB_RD_EN
    logic       req0_rd;
    logic       req1_rd;
    logic [7:0] psg_dout;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport slave (
        input  req0_valid, req0_addr, req0_din, req0_rd,
        input  req1_valid, req1_addr, req1_din, req1_rd,
        input  psg_dout,
        output req0_ack, req1_ack,
        output psg_addr, psg_din, psg_cs_n, psg_wr_n,
        output grant_id, busy, rd_data, rd_valid
    );
    modport master (
        output req0_valid, req0_addr, req0_din, req0_rd,
        output req1_valid, req1_addr, req1_din, req1_rd,
        output psg_dout,
        input  req0_ack, req1_ack,
        input  psg_addr, psg_din, psg_cs_n, psg_wr_n,
        input  grant_id, busy, rd_data, rd_valid
    );
`else
    modport slave (
        input  req0_valid, req0_addr, req0_din,
        input  req1_valid, req1_addr, req1_din,
        output req0_ack, req1_ack,
        output psg_addr, psg_din, psg_cs_n, psg_wr_n,
        output grant_id, busy
    );
    modport master (
        output req0_valid, req0_addr, req0_din,
        output req1_valid, req1_addr, req1_din,
        input  req0_ack, req1_ack,
        input  psg_addr, psg_din, psg_cs_n, psg_wr_n,
        input  grant_id, busy
    );
`endif
endinterface

// File: rtl/jt49_bus_arb.sv
// jt49_bus_arb: shares the jt49 register bus between req0 (host CPU) and req1 (music player).
// Latency: grant on the first edge a valid is seen; a write holds cs_n low SETUP+STROBE+RECOV cycles.
// Backpressure: a requester holds valid/payload until its one-cycle ack; losers wait in place.
//
// Ports: clk, rst_n (synchronous, active low), bus (jt49_bus_arb_if.slave):
//   reqN_valid/addr/din[/rd] in, reqN_ack out, psg_addr/din/cs_n/wr_n out, grant_id, busy out,
//   psg_dout in, rd_data/rd_valid out (reads only).
// Optional feature: define JT49_ARB_RD_EN to add read transactions (SETUP then one CAPT cycle).
// The recovery phase keeps cs_n low with wr_n high so each write gives the PSG a fresh wr_n
// falling edge; back-to-back writes to the envelope shape register 0xD each retrigger it.
module jt49_bus_arb #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int RECOV_CYC  = 1,
    parameter int PRIO       = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    jt49_bus_arb_if.slave  bus
);

    // Zero-length phases are stretched to one cycle.
    localparam int S_EFF = (SETUP_CYC  < 1) ? 1 : SETUP_CYC;
    localparam int T_EFF = (STROBE_CYC < 1) ? 1 : STROBE_CYC;
    localparam int R_EFF = (RECOV_CYC  < 1) ? 1 : RECOV_CYC;
    localparam int MAX_A = (S_EFF > T_EFF) ? S_EFF : T_EFF;
    localparam int MAX_C = (MAX_A > R_EFF) ? MAX_A : R_EFF;
    localparam int CW    = $clog2(MAX_C + 1);

    // The counter is loaded with length-1 on phase entry and the phase ends when it reads 0.
    localparam logic [CW-1:0] S_LD = CW'(S_EFF - 1);
    localparam logic [CW-1:0] T_LD = CW'(T_EFF - 1);
    localparam logic [CW-1:0] R_LD = CW'(R_EFF - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOV
`ifdef JT49_ARB_RD_EN
        , CAPT
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [3:0]    addr_q,  addr_d;
    logic [7:0]    din_q,   din_d;
    logic          gid_q,   gid_d;
    logic          rr_q,    rr_d;      // 0: req0 wins a tie next, 1: req1 does
    logic          ack0_q,  ack0_d;
    logic          ack1_q,  ack1_d;
    logic          cs_n_q,  cs_n_d;
    logic          wr_n_q,  wr_n_d;
    logic          pick1;
`ifdef JT49_ARB_RD_EN
    logic          rd_q,       rd_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q,  rd_data_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            gid_q   <= 1'b0;
            rr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
`ifdef JT49_ARB_RD_EN
            rd_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            gid_q   <= gid_d;
            rr_q    <= rr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            cs_n_q  <= cs_n_d;
            wr_n_q  <= wr_n_d;
`ifdef JT49_ARB_RD_EN
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        gid_d   = gid_q;
        rr_d    = rr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
`ifdef JT49_ARB_RD_EN
        rd_d       = rd_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
`endif

        // req1 wins if it is alone, or on a tie when round-robin points at it.
        if (PRIO != 0)
            pick1 = bus.req1_valid && !bus.req0_valid;
        else
            pick1 = bus.req1_valid && (!bus.req0_valid || rr_q);

        case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    state_d = SETUP;
                    cnt_d   = S_LD;
                    gid_d   = pick1;
                    rr_d    = ~pick1;
                    ack0_d  = ~pick1;
                    ack1_d  = pick1;
                    addr_d  = pick1 ? bus.req1_addr : bus.req0_addr;
                    din_d   = pick1 ? bus.req1_din  : bus.req0_din;
`ifdef JT49_ARB_RD_EN
                    rd_d    = pick1 ? bus.req1_rd   : bus.req0_rd;
`endif
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
`ifdef JT49_ARB_RD_EN
                    if (rd_q) begin
                        state_d = CAPT;
                    end else begin
                        state_d = STROBE;
                        cnt_d   = T_LD;
                    end
`else
                    state_d = STROBE;
                    cnt_d   = T_LD;
`endif
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_q == '0) begin
                    state_d = RECOV;
                    cnt_d   = R_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RECOV: begin
                if (cnt_q == '0)
                    state_d = IDLE;
                else
                    cnt_d = cnt_q - CW'(1);
            end
`ifdef JT49_ARB_RD_EN
            CAPT: begin
                state_d    = IDLE;
                rd_valid_d = 1'b1;
                rd_data_d  = bus.psg_dout;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Strobes are registered from the next state so they switch cleanly with it.
        cs_n_d = (state_d == IDLE);
        wr_n_d = (state_d != STROBE);
    end

    assign bus.psg_addr = addr_q;
    assign bus.psg_din  = din_q;
    assign bus.psg_cs_n = cs_n_q;
    assign bus.psg_wr_n = wr_n_q;
    assign bus.req0_ack = ack0_q;
    assign bus.req1_ack = ack1_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = (state_q != IDLE);
`ifdef JT49_ARB_RD_EN
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_jt49_bus_arb.sv
// tb_jt49_bus_arb: scoreboard bench for jt49_bus_arb; dut k=0 is round-robin, k=1 is req0-priority.
// Expected transactions are queued when requests are issued and popped as each cs_n window ends.
module tb_jt49_bus_arb;

    typedef struct packed {
        logic       id;
        logic [3:0] addr;
        logic [7:0] din;    // write data, or expected read data for reads
        logic       rd;
        logic       gap;    // expect exactly one idle cycle before this window
    } txn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jt49_bus_arb_if bus_rr ();
    jt49_bus_arb_if bus_pr ();

    jt49_bus_arb #(.PRIO(0)) dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
    jt49_bus_arb #(.PRIO(1)) dut_pr (.clk(clk), .rst_n(rst_n), .bus(bus_pr));

    // requester-side drive, indexed [dut][requester]
    logic       vld   [2][2];
    logic [3:0] raddr [2][2];
    logic [7:0] rdin  [2][2];
    logic       rrd   [2][2];

    // observed outputs
    logic [1:0] cs_n, wr_n, busy, gid, ack0, ack1, rdv;
    logic [3:0] paddr [2];
    logic [7:0] pdin  [2];
    logic [7:0] rdd   [2];

    assign bus_rr.req0_valid = vld[0][0];   assign bus_rr.req1_valid = vld[0][1];
    assign bus_rr.req0_addr  = raddr[0][0]; assign bus_rr.req1_addr  = raddr[0][1];
    assign bus_rr.req0_din   = rdin[0][0];  assign bus_rr.req1_din   = rdin[0][1];
    assign bus_pr.req0_valid = vld[1][0];   assign bus_pr.req1_valid = vld[1][1];
    assign bus_pr.req0_addr  = raddr[1][0]; assign bus_pr.req1_addr  = raddr[1][1];
    assign bus_pr.req0_din   = rdin[1][0];  assign bus_pr.req1_din   = rdin[1][1];

    assign cs_n[0] = bus_rr.psg_cs_n; assign cs_n[1] = bus_pr.psg_cs_n;
    assign wr_n[0] = bus_rr.psg_wr_n; assign wr_n[1] = bus_pr.psg_wr_n;
    assign busy[0] = bus_rr.busy;     assign busy[1] = bus_pr.busy;
    assign gid[0]  = bus_rr.grant_id; assign gid[1]  = bus_pr.grant_id;
    assign ack0[0] = bus_rr.req0_ack; assign ack0[1] = bus_pr.req0_ack;
    assign ack1[0] = bus_rr.req1_ack; assign ack1[1] = bus_pr.req1_ack;
    assign paddr[0] = bus_rr.psg_addr; assign paddr[1] = bus_pr.psg_addr;
    assign pdin[0]  = bus_rr.psg_din;  assign pdin[1]  = bus_pr.psg_din;

    // small PSG register file model so reads return what was written
    logic [7:0] regs [2][16];

`ifdef JT49_ARB_RD_EN
    assign bus_rr.req0_rd = rrd[0][0]; assign bus_rr.req1_rd = rrd[0][1];
    assign bus_pr.req0_rd = rrd[1][0]; assign bus_pr.req1_rd = rrd[1][1];
    assign bus_rr.psg_dout = regs[0][bus_rr.psg_addr];
    assign bus_pr.psg_dout = regs[1][bus_pr.psg_addr];
    assign rdv[0] = bus_rr.rd_valid;  assign rdv[1] = bus_pr.rd_valid;
    assign rdd[0] = bus_rr.rd_data;   assign rdd[1] = bus_pr.rd_data;
`else
    assign rdv = 2'b00;
    assign rdd[0] = 8'h00;
    assign rdd[1] = 8'h00;
`endif

    txn_t drv_q [2][2][$];
    txn_t exp_q [2][$];
    int   pushed [2];
    int   acks   [2];
    int   falls  [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int k, input int r, input logic [3:0] a, input logic [7:0] d,
                        input logic rd, input logic gap);
        txn_t t;
        t.id = r[0]; t.addr = a; t.din = d; t.rd = rd; t.gap = gap;
        drv_q[k][r].push_back(t);
        exp_q[k].push_back(t);
        pushed[k]++;
    endtask

    task automatic wait_done(input int k, input string tag);
        int n = 0;
        while ((exp_q[k].size() > 0 || drv_q[k][0].size() > 0 || drv_q[k][1].size() > 0)
               && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " completes"}, (n < 1000), 1);
    endtask

    // requesters: present the queue head, advance when it is acked
    initial begin
        txn_t t;
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 2; r++) begin
                vld[k][r] = 1'b0; raddr[k][r] = '0; rdin[k][r] = '0; rrd[k][r] = 1'b0;
            end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                for (int r = 0; r < 2; r++) begin
                    if (!rst_n) begin
                        vld[k][r] = 1'b0;
                    end else begin
                        if (vld[k][r] && (r == 0 ? ack0[k] : ack1[k]) && drv_q[k][r].size() > 0)
                            void'(drv_q[k][r].pop_front());
                        if (drv_q[k][r].size() > 0) begin
                            t = drv_q[k][r][0];
                            vld[k][r] = 1'b1; raddr[k][r] = t.addr;
                            rdin[k][r] = t.din; rrd[k][r] = t.rd;
                        end else begin
                            vld[k][r] = 1'b0;
                        end
                    end
                end
        end
    end

    // bus monitor / scoreboard
    int         low_len  [2];
    int         high_len [2];
    int         gap0     [2];
    logic [15:0] wr_pat  [2];
    logic [3:0] a0 [2];
    logic [7:0] d0 [2];
    logic       g0 [2];
    logic       stable [2];
    logic       busy_ok [2];
    logic       prev_wr [2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            low_len[k] = 0; high_len[k] = 0; gap0[k] = 0; wr_pat[k] = '0;
            prev_wr[k] = 1'b1; pushed[k] = 0; acks[k] = 0; falls[k] = 0;
            for (int i = 0; i < 16; i++) regs[k][i] = 8'h00;
        end
    end

    always @(negedge clk) begin
        txn_t e;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                low_len[k] = 0; high_len[k] = 0; prev_wr[k] = 1'b1;
            end else begin
                if (ack0[k] || ack1[k]) begin
                    acks[k]++;
                    check($sformatf("dut%0d single ack", k), {31'b0, ack0[k] & ack1[k]}, 0);
                    check($sformatf("dut%0d ack matches grant_id", k), {31'b0, gid[k]}, {31'b0, ack1[k]});
                end
                if (prev_wr[k] && !wr_n[k]) falls[k]++;
                prev_wr[k] = wr_n[k];
                if (!cs_n[k]) begin
                    if (!wr_n[k]) regs[k][paddr[k]] = pdin[k];
                    if (low_len[k] == 0) begin
                        a0[k] = paddr[k]; d0[k] = pdin[k]; g0[k] = gid[k];
                        wr_pat[k] = '0; stable[k] = 1'b1; busy_ok[k] = 1'b1;
                        gap0[k] = high_len[k];
                    end
                    if (paddr[k] != a0[k] || pdin[k] != d0[k]) stable[k] = 1'b0;
                    if (!busy[k]) busy_ok[k] = 1'b0;
                    if (!wr_n[k] && low_len[k] < 16) wr_pat[k][low_len[k]] = 1'b1;
                    low_len[k]++;
                    high_len[k] = 0;
                end else begin
                    if (low_len[k] > 0) begin
                        if (exp_q[k].size() == 0) begin
                            check($sformatf("dut%0d unexpected transaction", k), 1, 0);
                        end else begin
                            e = exp_q[k].pop_front();
                            check($sformatf("dut%0d grant_id", k), {31'b0, g0[k]}, {31'b0, e.id});
                            check($sformatf("dut%0d addr", k), {28'b0, a0[k]}, {28'b0, e.addr});
                            check($sformatf("dut%0d din", k), {24'b0, d0[k]}, {24'b0, e.din});
                            check($sformatf("dut%0d cs_n low cycles", k), low_len[k], e.rd ? 2 : 4);
                            check($sformatf("dut%0d wr_n low pattern", k), {16'b0, wr_pat[k]},
                                  e.rd ? 32'h0 : 32'h6);
                            check($sformatf("dut%0d addr/din stable", k), {31'b0, stable[k]}, 1);
                            check($sformatf("dut%0d busy in window", k), {31'b0, busy_ok[k]}, 1);
                            if (e.gap)
                                check($sformatf("dut%0d idle gap", k), gap0[k], 1);
`ifdef JT49_ARB_RD_EN
                            check($sformatf("dut%0d rd_valid", k), {31'b0, rdv[k]}, {31'b0, e.rd});
                            if (e.rd)
                                check($sformatf("dut%0d rd_data", k), {24'b0, rdd[k]}, {24'b0, e.din});
`endif
                        end
                    end
                    low_len[k] = 0;
                    high_len[k]++;
                end
            end
        end
    end

    initial begin
        int n;
        int fall_base;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("dut%0d reset cs_n", k), {31'b0, cs_n[k]}, 1);
            check($sformatf("dut%0d reset wr_n", k), {31'b0, wr_n[k]}, 1);
            check($sformatf("dut%0d reset busy", k), {31'b0, busy[k]}, 0);
            check($sformatf("dut%0d reset grant_id", k), {31'b0, gid[k]}, 0);
            check($sformatf("dut%0d reset acks", k), {30'b0, ack1[k], ack0[k]}, 0);
            check($sformatf("dut%0d reset addr/din", k), {20'b0, paddr[k], pdin[k]}, 0);
            check($sformatf("dut%0d reset rd_valid/rd_data", k), {23'b0, rdv[k], rdd[k]}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // round-robin from reset: both valid together, grants alternate 0,1,0,1
        @(posedge clk);
        push(0, 0, 4'h1, 8'h11, 1'b0, 1'b0);
        push(0, 1, 4'h2, 8'h22, 1'b0, 1'b1);
        push(0, 0, 4'h3, 8'h33, 1'b0, 1'b1);
        push(0, 1, 4'h4, 8'h44, 1'b0, 1'b1);
        wait_done(0, "rr alternation");

        // fixed priority: req0 keeps winning while it has work
        @(posedge clk);
        push(1, 0, 4'h8, 8'h81, 1'b0, 1'b0);
        push(1, 0, 4'h9, 8'h82, 1'b0, 1'b1);
        push(1, 0, 4'hA, 8'h83, 1'b0, 1'b1);
        push(1, 1, 4'hB, 8'h91, 1'b0, 1'b1);
        wait_done(1, "priority");

        // single envelope-shape write from req0
        @(posedge clk);
        push(0, 0, 4'hD, 8'h0E, 1'b0, 1'b0);
        wait_done(0, "single write");

        // two back-to-back req1 writes to 0xD give two separate wr_n falling edges
        fall_base = falls[0];
        @(posedge clk);
        push(0, 1, 4'hD, 8'h09, 1'b0, 1'b0);
        push(0, 1, 4'hD, 8'h0D, 1'b0, 1'b1);
        wait_done(0, "envelope retrigger");
        check("envelope wr_n falling edges", falls[0] - fall_base, 2);

        // reset during STROBE aborts the write at once
        @(posedge clk);
        push(0, 0, 4'h5, 8'h55, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_n[0] && n < 50);
        check("reached strobe", {31'b0, wr_n[0]}, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort cs_n", {31'b0, cs_n[0]}, 1);
        check("abort wr_n", {31'b0, wr_n[0]}, 1);
        check("abort busy", {31'b0, busy[0]}, 0);
        check("abort acks", {30'b0, ack1[0], ack0[0]}, 0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        push(0, 0, 4'h6, 8'h66, 1'b0, 1'b0);
        push(0, 1, 4'h7, 8'h77, 1'b0, 1'b1);
        wait_done(0, "post-reset rr");

`ifdef JT49_ARB_RD_EN
        // write then read back through req1
        @(posedge clk);
        push(0, 0, 4'h2, 8'h5A, 1'b0, 1'b0);
        wait_done(0, "write before read");
        @(posedge clk);
        push(0, 1, 4'h2, 8'h5A, 1'b1, 1'b0);
        wait_done(0, "read");
`endif

        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("dut%0d ack count", k), acks[k], pushed[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
